// File: rtl/digit_serial_addsub.sv
// Digit-serial adder/subtractor: DIGIT bits per clock, LSB digit first, valid/ready in and out.
// Optional build macro ADDSUB_SAT_EN: on signed overflow the result saturates instead of wrapping.
module digit_serial_addsub #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;
`ifdef ADDSUB_SAT_EN
  logic             r_a_msb;
`endif

  logic             w_accept;
  logic             w_run;
  logic             w_last;
  logic [DIGIT:0]   w_dadd;
  logic [DIGIT-1:0] w_dsum;
  logic             w_dcarry;
  logic             w_c_msb;
  logic             w_ovf;
  logic [WIDTH-1:0] w_psum_next;
  logic [WIDTH-1:0] w_result;

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign ovf       = r_ovf;

  assign w_accept = in_valid && (r_state == S_IDLE);
  assign w_run    = (r_state == S_RUN);
  assign w_last   = w_run && (r_cnt == LAST);

  // Operands are shifted right each digit, so the active digit is always at bit 0.
  assign w_dadd   = {1'b0, r_a_sh[DIGIT-1:0]} + {1'b0, r_b_sh[DIGIT-1:0]}
                  + {{DIGIT{1'b0}}, r_carry};
  assign w_dsum   = w_dadd[DIGIT-1:0];
  assign w_dcarry = w_dadd[DIGIT];
  // Carry into the result MSB, recovered from the MSB's own sum bit on the last digit.
  assign w_c_msb  = r_a_sh[DIGIT-1] ^ r_b_sh[DIGIT-1] ^ w_dsum[DIGIT-1];
  assign w_ovf    = w_c_msb ^ w_dcarry;

  generate
    if (DIGIT == WIDTH) begin : g_single
      assign w_psum_next = w_dsum;
    end else begin : g_multi
      // Holds the N-1 most recent digit results; each new digit enters at the top.
      logic [WIDTH-DIGIT-1:0] r_psum;

      always_ff @(posedge clk) begin
        if (rst) begin
          r_psum <= '0;
        end else if (w_run) begin
          r_psum <= w_psum_next[WIDTH-1:DIGIT];
        end
      end

      assign w_psum_next = {w_dsum, r_psum};
    end
  endgenerate

  always_comb begin
    w_result = w_psum_next;
`ifdef ADDSUB_SAT_EN
    if (w_ovf) begin
      w_result = {r_a_msb, {(WIDTH-1){~r_a_msb}}};
    end
`endif
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (in_valid) w_state_next = S_RUN;
      S_RUN:   if (r_cnt == LAST) w_state_next = S_DONE;
      S_DONE:  if (out_ready) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_sh  <= '0;
      r_b_sh  <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
`ifdef ADDSUB_SAT_EN
      r_a_msb <= 1'b0;
`endif
    end else if (w_accept) begin
      r_a_sh  <= a;
      r_b_sh  <= sub ? ~b : b;
      r_carry <= sub ? ~cin : cin;
      r_cnt   <= '0;
`ifdef ADDSUB_SAT_EN
      r_a_msb <= a[WIDTH-1];
`endif
    end else if (w_run) begin
      r_a_sh  <= r_a_sh >> DIGIT;
      r_b_sh  <= r_b_sh >> DIGIT;
      r_carry <= w_dcarry;
      r_cnt   <= w_last ? '0 : r_cnt + CW'(1);
    end
  end

  // Result registers change only on the completing digit, so they stay frozen through DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sum  <= '0;
      r_cout <= 1'b0;
      r_ovf  <= 1'b0;
    end else if (w_last) begin
      r_sum  <= w_result;
      r_cout <= w_dcarry;
      r_ovf  <= w_ovf;
    end
  end

endmodule
